// File: rtl/alu_issue.sv
// alu_issue: sequences one register-to-register instruction through an
// external combinational ALU and retires the result into an internal
// 8-entry register file.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for an instruction; instr_ready high
// READ  | operands read from the register file and driven to the ALU
// EXEC  | ALU lines valid; the result and flags are captured at the closing edge
// WB    | done high; the low half is written to R[rd] unless the instruction faulted
module alu_issue #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic [3:0]         instr_op,
   input  logic [2:0]         instr_rd,
   input  logic [2:0]         instr_rs1,
   input  logic [2:0]         instr_rs2,
   input  logic               ld_en,
   input  logic [2:0]         ld_addr,
   input  logic [WIDTH-1:0]   ld_data,
   input  logic [2:0]         rd_addr,
   output logic [WIDTH-1:0]   rd_data,
   output logic [WIDTH-1:0]   alu_in1,
   output logic [WIDTH-1:0]   alu_in2,
   output logic [3:0]         alu_op,
   output logic               alu_nvalid_data,
   input  logic [2*WIDTH-1:0] alu_out,
   input  logic               alu_error,
   output logic               done,
   output logic [WIDTH-1:0]   hi,
   output logic               flag_zero,
   output logic               flag_error
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      EXEC = 2'd2,
      WB   = 2'd3
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [3:0]         op_q;
   logic [2:0]         rd_q;
   logic [2:0]         rs1_q;
   logic [2:0]         rs2_q;
   logic [WIDTH-1:0]   regs [8];
   logic [WIDTH-1:0]   res_lo_q;
   logic               fault_q;
   logic               fault;
   logic               accept;
   logic [2*WIDTH-1:0] res_capt;

   assign accept  = instr_valid && instr_ready;
   assign rd_data = regs[rd_addr];

   // Fault and captured result. alu_error only matters for divide, since the
   // ALU also raises it for a zero second operand on the other ops.
   always_comb begin
      fault    = ((op_q == 4'd3) && (alu_error || (alu_in2 == '0))) || (op_q > 4'd3);
      res_capt = (op_q > 4'd3) ? '0 : alu_out;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state and handshake decode.
   always_comb begin
      state_d     = state_q;
      instr_ready = 1'b0;
      case (state_q)
         IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) state_d = READ;
         end
         READ:    state_d = EXEC;
         EXEC:    state_d = WB;
         WB:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Instruction latch, ALU drive and result capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q            <= '0;
         rd_q            <= '0;
         rs1_q           <= '0;
         rs2_q           <= '0;
         alu_in1         <= '0;
         alu_in2         <= '0;
         alu_op          <= '0;
         alu_nvalid_data <= 1'b0;
         res_lo_q        <= '0;
         fault_q         <= 1'b0;
         done            <= 1'b0;
         hi              <= '0;
         flag_zero       <= 1'b0;
         flag_error      <= 1'b0;
      end else begin
         if (accept) begin
            op_q  <= instr_op;
            rd_q  <= instr_rd;
            rs1_q <= instr_rs1;
            rs2_q <= instr_rs2;
         end
         if (state_q == READ) begin
            alu_in1         <= regs[rs1_q];
            alu_in2         <= regs[rs2_q];
            alu_op          <= op_q;
            alu_nvalid_data <= 1'b1;
         end
         if (state_q == EXEC) begin
            res_lo_q        <= res_capt[WIDTH-1:0];
            hi              <= res_capt[2*WIDTH-1:WIDTH];
            flag_zero       <= (res_capt == '0);
            flag_error      <= fault;
            fault_q         <= fault;
            done            <= 1'b1;
            alu_nvalid_data <= 1'b0;
         end
         if (state_q == WB) done <= 1'b0;
      end
   end

   // Register file; the writeback is the later assignment so it beats a
   // preload to the same index on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) regs[i] <= '0;
      end else begin
         if (ld_en) regs[ld_addr] <= ld_data;
         if ((state_q == WB) && !fault_q) regs[rd_q] <= res_lo_q;
      end
   end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: a behavioural ALU, a transaction-level model of the
// issue stage, a per-cycle compare process and directed literal checks.
module tb_alu_issue;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           instr_valid;
   logic           instr_ready;
   logic [3:0]     instr_op;
   logic [2:0]     instr_rd, instr_rs1, instr_rs2;
   logic           ld_en;
   logic [2:0]     ld_addr;
   logic [W-1:0]   ld_data;
   logic [2:0]     rd_addr;
   logic [W-1:0]   rd_data;
   logic [W-1:0]   alu_in1, alu_in2;
   logic [3:0]     alu_op;
   logic           alu_nvalid_data;
   logic [2*W-1:0] alu_out;
   logic           alu_error;
   logic           done;
   logic [W-1:0]   hi;
   logic           flag_zero, flag_error;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   alu_issue #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
      .alu_nvalid_data(alu_nvalid_data),
      .alu_out(alu_out), .alu_error(alu_error),
      .done(done), .hi(hi), .flag_zero(flag_zero), .flag_error(flag_error)
   );

   // Behavioural ALU: divide by zero returns all ones, illegal ops return 0,
   // and the error line rises whenever the second operand is zero.
   function automatic logic [2*W-1:0] alu_f(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-1:0] xa, xb;
      xa = {{W{1'b0}}, a};
      xb = {{W{1'b0}}, b};
      case (op)
         4'd0:    return xa + xb;
         4'd1:    return xa - xb;
         4'd2:    return xa * xb;
         4'd3:    return (b == '0) ? {2*W{1'b1}} : xa / xb;
         default: return '0;
      endcase
   endfunction

   assign alu_out   = alu_f(alu_op, alu_in1, alu_in2);
   assign alu_error = (alu_in2 == '0);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: cycles since accept, register file contents and the
   // retired-result flags, all derived from the instruction-level rules.
   int           m_since;
   logic [3:0]   m_op;
   logic [2:0]   m_rd, m_rs1, m_rs2;
   logic [W-1:0] m_a, m_b;
   logic [2*W-1:0] m_res;
   bit           m_fault;
   logic [W-1:0] m_r [8];
   logic [W-1:0] m_hi;
   bit           m_fz, m_fe;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_since = 0; m_op = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0;
         m_a = 0; m_b = 0; m_res = 0; m_fault = 0;
         for (int i = 0; i < 8; i++) m_r[i] = 0;
         m_hi = 0; m_fz = 0; m_fe = 0;
      end else begin
         int s;
         s = m_since;
         if (s == 0) begin
            if (instr_valid) begin
               m_op = instr_op; m_rd = instr_rd; m_rs1 = instr_rs1; m_rs2 = instr_rs2;
               m_since = 1;
            end
         end else if (s == 1) begin
            m_a = m_r[m_rs1];
            m_b = m_r[m_rs2];
            m_since = 2;
         end else if (s == 2) begin
            m_res   = (m_op > 3) ? '0 : alu_f(m_op, m_a, m_b);
            m_fault = (m_op > 3) || (m_op == 3 && m_b == 0);
            m_hi    = m_res[2*W-1:W];
            m_fz    = (m_res == 0);
            m_fe    = m_fault;
            m_since = 3;
         end else begin
            m_since = 0;
         end
         if (ld_en) m_r[ld_addr] = ld_data;
         if (s == 3 && !m_fault) m_r[m_rd] = m_res[W-1:0];
      end
   end

   // Per-cycle compare of every DUT output against the model.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("instr_ready", instr_ready, (m_since == 0));
         chk("done", done, (m_since == 3));
         chk("alu_nvalid_data", alu_nvalid_data, (m_since == 2));
         chk("hi", hi, m_hi);
         chk("flag_zero", flag_zero, m_fz);
         chk("flag_error", flag_error, m_fe);
         chk("rd_data", rd_data, m_r[rd_addr]);
         if (m_since == 2) begin
            chk("alu_in1", alu_in1, m_a);
            chk("alu_in2", alu_in2, m_b);
            chk("alu_op", alu_op, m_op);
         end
      end
   end

   task automatic preload(input logic [2:0] a, input logic [W-1:0] d);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   // Issues one instruction from an idle negedge and returns four negedges
   // later, back in IDLE, with rd_addr pointing at the destination.
   task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input bit ld_wb, input bit rnd_ld,
                        output int done_at, output int nv_cnt);
      instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
      rd_addr = rd;
      @(posedge clk);
      #1 instr_valid = 1'b0;
      done_at = 0; nv_cnt = 0;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         if (done && done_at == 0) done_at = i;
         if (alu_nvalid_data) nv_cnt++;
         if (rnd_ld) begin
            ld_en = 1'($urandom_range(0, 1)); ld_addr = 3'($urandom); ld_data = 8'($urandom);
         end else if (ld_wb && i == 3) begin
            ld_en = 1'b1; ld_addr = rd; ld_data = 8'hAA;
         end else begin
            ld_en = 1'b0;
         end
      end
      ld_en = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int da, nc, acc, cyc, seen;
      int t_acc [3];
      instr_valid = 0; instr_op = 0; instr_rd = 0; instr_rs1 = 0; instr_rs2 = 0;
      ld_en = 0; ld_addr = 0; ld_data = 0; rd_addr = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      chk("reset instr_ready", instr_ready, 1);
      chk("reset done", done, 0);
      chk("reset hi", hi, 0);
      chk("reset alu_nvalid_data", alu_nvalid_data, 0);
      rd_addr = 3'd5; #1 chk("reset R5", rd_data, 0);
      @(negedge clk);

      // add
      preload(1, 8'd7); preload(2, 8'd5);
      issue(0, 3, 1, 2, 0, 0, da, nc);
      chk("add latency", da, 3);
      chk("add nvalid cycles", nc, 1);
      chk("add R3", rd_data, 8'd12);
      chk("add hi", hi, 0);
      chk("add flag_zero", flag_zero, 0);
      chk("add flag_error", flag_error, 0);

      // sub wrap, mul high half
      preload(1, 8'd3); preload(2, 8'd5);
      issue(1, 4, 1, 2, 0, 0, da, nc);
      chk("sub R4", rd_data, 8'hFE);
      chk("sub hi", hi, 8'hFF);
      preload(1, 8'h20); preload(2, 8'h10);
      issue(2, 5, 1, 2, 0, 0, da, nc);
      chk("mul R5", rd_data, 8'h00);
      chk("mul hi", hi, 8'h02);
      chk("mul flag_zero", flag_zero, 0);

      // divide by zero faults; add with in2 == 0 does not
      preload(6, 8'h55); preload(1, 8'd9); preload(2, 8'd0);
      issue(3, 6, 1, 2, 0, 0, da, nc);
      chk("div0 flag_error", flag_error, 1);
      chk("div0 R6 kept", rd_data, 8'h55);
      issue(0, 6, 1, 2, 0, 0, da, nc);
      chk("add in2=0 flag_error", flag_error, 0);
      chk("add in2=0 R6", rd_data, 8'd9);

      // illegal op, aliasing
      preload(7, 8'h33);
      issue(7, 7, 1, 2, 0, 0, da, nc);
      chk("illegal flag_error", flag_error, 1);
      chk("illegal flag_zero", flag_zero, 1);
      chk("illegal R7 kept", rd_data, 8'h33);
      preload(1, 8'd4);
      issue(0, 1, 1, 1, 0, 0, da, nc);
      chk("alias R1", rd_data, 8'd8);

      // instr_valid held high for three instructions
      preload(1, 8'd1); preload(2, 8'd2);
      instr_valid = 1; instr_op = 0; instr_rd = 3; instr_rs1 = 1; instr_rs2 = 2;
      acc = 0; cyc = 0;
      while (acc < 3 && cyc < 20) begin
         if (instr_ready) begin t_acc[acc] = cyc; acc++; end
         @(negedge clk);
         cyc++;
      end
      instr_valid = 0;
      chk("b2b accepts", acc, 3);
      chk("b2b spacing 1", t_acc[1] - t_acc[0], 4);
      chk("b2b spacing 2", t_acc[2] - t_acc[1], 4);
      repeat (3) @(negedge clk);

      // preload to rd during WB loses to the writeback
      preload(1, 8'h10); preload(2, 8'h01);
      issue(0, 3, 1, 2, 1, 0, da, nc);
      chk("wb beats ld R3", rd_data, 8'h11);

      // reset during EXEC
      preload(1, 8'd5); preload(2, 8'd6);
      instr_valid = 1; instr_op = 0; instr_rd = 4; instr_rs1 = 1; instr_rs2 = 2;
      @(posedge clk);
      #1 instr_valid = 0;
      @(negedge clk);
      @(negedge clk);
      #1 rst_n = 1'b0;
      rd_addr = 3'd1;
      #1;
      chk("rst alu_nvalid_data", alu_nvalid_data, 0);
      chk("rst alu_in1", alu_in1, 0);
      chk("rst alu_in2", alu_in2, 0);
      chk("rst instr_ready", instr_ready, 1);
      chk("rst R1", rd_data, 0);
      seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      chk("rst no done", seen, 0);
      rst_n = 1'b1;
      @(negedge clk);
      preload(1, 8'd2); preload(2, 8'd3);
      issue(0, 4, 1, 2, 0, 0, da, nc);
      chk("post-rst latency", da, 3);
      chk("post-rst R4", rd_data, 8'd5);

      // randomized instructions with random preloads
      repeat (80) begin
         logic [3:0] op;
         if ($urandom_range(0, 1) == 0) preload(3'($urandom), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom));
         op = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
         issue(op, 3'($urandom), 3'($urandom), 3'($urandom), 0, 1, da, nc);
         chk("rnd latency", da, 3);
         if ($urandom_range(0, 2) == 0) @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
